hazard_ctrl: RTL and testbench

Pipeline hazard controller that drives the hold/flush controls of the IF/ID and ID/EX pipeline registers and the PC write enable. It inserts load-use bubbles and squashes wrong-path instructions on a taken branch. It also freezes the front end while a multi-cycle multiply/divide occupies EX. It sits beside the decode stage: it consumes decode-stage register numbers and ID/EX-stage status, and its outputs feed the `stall`/`flush` inputs of the pipeline registers.

---
 rtl/hazard_ctrl_if.sv | 31 +++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decode/ID-EX status in, pipeline hold/flush controls out.
// The pipeline side uses master; the controller uses slave.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs_id;
  logic [4:0]       rt_id;
  logic             uses_rt_id;
  logic             mem_read_id_ex;
  logic [4:0]       wr_num_id_ex;
  logic             md_id_ex;
  logic             branch_taken_ex;
  logic             pc_we;
  logic             if_id_we;
  logic             flush_if_id;
  logic             stall_id_ex;
  logic             flush_id_ex;
  logic             bubble_ex_mem;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output rs_id, rt_id, uses_rt_id, mem_read_id_ex, wr_num_id_ex, md_id_ex, branch_taken_ex,
    input  pc_we, if_id_we, flush_if_id, stall_id_ex, flush_id_ex, bubble_ex_mem, md_done, stall_cnt
  );

  modport slave (
    input  rs_id, rt_id, uses_rt_id, mem_read_id_ex, wr_num_id_ex, md_id_ex, branch_taken_ex,
    output pc_we, if_id_we, flush_if_id, stall_id_ex, flush_id_ex, bubble_ex_mem, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch squash, and
// front-end freeze while a multi-cycle mult/div occupies EX.
//
// state   | meaning
// RUN     | normal issue; branch / mult-div entry / load-use checked in priority order
// MD_BUSY | mult/div in EX; freeze while cnt != 0, release cycle when cnt == 0
module hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  localparam int CW = $clog2(MD_CYCLES);
  // Entry cycle is the first freeze, so the counter covers the remaining MD_CYCLES-2.
  localparam logic [CW-1:0] CNT_LOAD = CW'(MD_CYCLES - 2);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;

  assign load_use = hz.mem_read_id_ex && (hz.wr_num_id_ex != 5'd0) &&
                    ((hz.wr_num_id_ex == hz.rs_id) ||
                     (hz.uses_rt_id && (hz.wr_num_id_ex == hz.rt_id)));

  assign hz.stall_cnt = stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (!hz.pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    hz.pc_we         = 1'b1;
    hz.if_id_we      = 1'b1;
    hz.flush_if_id   = 1'b0;
    hz.stall_id_ex   = 1'b0;
    hz.flush_id_ex   = 1'b0;
    hz.bubble_ex_mem = 1'b0;
    hz.md_done       = 1'b0;
    state_nxt        = state;
    cnt_nxt          = cnt;

    if (!rst_n) begin
      hz.pc_we         = 1'b0;
      hz.if_id_we      = 1'b0;
      hz.flush_if_id   = 1'b1;
      hz.flush_id_ex   = 1'b1;
      hz.bubble_ex_mem = 1'b1;
      state_nxt        = RUN;
      cnt_nxt          = '0;
    end else begin
      case (state)
        RUN: begin
          if (hz.branch_taken_ex) begin
            hz.flush_if_id = 1'b1;
            hz.flush_id_ex = 1'b1;
          end else if (hz.md_id_ex) begin
            hz.pc_we         = 1'b0;
            hz.if_id_we      = 1'b0;
            hz.stall_id_ex   = 1'b1;
            hz.bubble_ex_mem = 1'b1;
            cnt_nxt          = CNT_LOAD;
            state_nxt        = MD_BUSY;
          end else if (load_use) begin
            hz.pc_we       = 1'b0;
            hz.if_id_we    = 1'b0;
            hz.flush_id_ex = 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt != '0) begin
            hz.pc_we         = 1'b0;
            hz.if_id_we      = 1'b0;
            hz.stall_id_ex   = 1'b1;
            hz.bubble_ex_mem = 1'b1;
            cnt_nxt          = cnt - CW'(1);
          end else begin
            // md_id_ex is still high here (the op leaves ID/EX at this edge) and must not re-trigger.
            hz.md_done = 1'b1;
            state_nxt  = RUN;
            if (load_use) begin
              hz.pc_we       = 1'b0;
              hz.if_id_we    = 1'b0;
              hz.flush_id_ex = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (MD_CYCLES=4/CNT_W=16 and MD_CYCLES=2/CNT_W=4)
// driven by the same stimulus and compared each cycle against an age-based reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_id, rt_id, wr_num_id_ex;
  logic       uses_rt_id, mem_read_id_ex, md_id_ex, branch_taken_ex;

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: EX cycles already spent by an active mult/div, and the stall count.
  int age_a, age_b, sc_a, sc_b;
  logic [6:0] ea, eb;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) hz_a ();
  hazard_ctrl_if #(.CNT_W(4))  hz_b ();

  assign hz_a.rs_id = rs_id;               assign hz_b.rs_id = rs_id;
  assign hz_a.rt_id = rt_id;               assign hz_b.rt_id = rt_id;
  assign hz_a.uses_rt_id = uses_rt_id;     assign hz_b.uses_rt_id = uses_rt_id;
  assign hz_a.mem_read_id_ex = mem_read_id_ex;
  assign hz_b.mem_read_id_ex = mem_read_id_ex;
  assign hz_a.wr_num_id_ex = wr_num_id_ex; assign hz_b.wr_num_id_ex = wr_num_id_ex;
  assign hz_a.md_id_ex = md_id_ex;         assign hz_b.md_id_ex = md_id_ex;
  assign hz_a.branch_taken_ex = branch_taken_ex;
  assign hz_b.branch_taken_ex = branch_taken_ex;

  hazard_ctrl #(.MD_CYCLES(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hz(hz_a));
  hazard_ctrl #(.MD_CYCLES(2), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .hz(hz_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Output bits: {pc_we, if_id_we, flush_if_id, stall_id_ex, flush_id_ex, bubble_ex_mem, md_done}
  function automatic logic [6:0] exp_out(input int md_cyc, input int age);
    logic lu;
    lu = mem_read_id_ex && (wr_num_id_ex != 0) &&
         ((wr_num_id_ex == rs_id) || (uses_rt_id && (wr_num_id_ex == rt_id)));
    if (!rst_n)                        return 7'b0010110;
    if (age > 0 && age + 1 < md_cyc)   return 7'b0001010;
    if (age > 0)                       return lu ? 7'b0000101 : 7'b1100001;
    if (branch_taken_ex)               return 7'b1110100;
    if (md_id_ex)                      return 7'b0001010;
    if (lu)                            return 7'b0000100;
    return 7'b1100000;
  endfunction

  task automatic model_update(input int md_cyc, input int cmax, input logic [6:0] e,
                              inout int age, inout int sc);
    if (!rst_n) begin
      age = 0;
      sc  = 0;
    end else begin
      if (!e[6] && sc < cmax) sc++;
      if (age > 0)                          age = (age + 1 >= md_cyc) ? 0 : age + 1;
      else if (!branch_taken_ex && md_id_ex) age = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    ea = exp_out(4, age_a);
    eb = exp_out(2, age_b);
    chk("outs_a", {hz_a.pc_we, hz_a.if_id_we, hz_a.flush_if_id, hz_a.stall_id_ex,
                   hz_a.flush_id_ex, hz_a.bubble_ex_mem, hz_a.md_done}, ea);
    chk("outs_b", {hz_b.pc_we, hz_b.if_id_we, hz_b.flush_if_id, hz_b.stall_id_ex,
                   hz_b.flush_id_ex, hz_b.bubble_ex_mem, hz_b.md_done}, eb);
    chk("cnt_a", hz_a.stall_cnt, sc_a);
    chk("cnt_b", hz_b.stall_cnt, sc_b);
    @(posedge clk);
    model_update(4, 65535, ea, age_a, sc_a);
    model_update(2, 15, eb, age_b, sc_b);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; rs_id = 5'd1; rt_id = 5'd2; uses_rt_id = 1'b0;
    mem_read_id_ex = 1'b0; wr_num_id_ex = 5'd0; md_id_ex = 1'b0; branch_taken_ex = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    age_a = 0; age_b = 0; sc_a = 0; sc_b = 0;

    // Load-use hit on rs
    do_reset();
    mem_read_id_ex = 1'b1; wr_num_id_ex = 5'd5; rs_id = 5'd5;
    step();
    chk("lu_stall_cnt", hz_a.stall_cnt, 1);
    idle(); step();

    // Filters: rt match without uses_rt, and $0
    mem_read_id_ex = 1'b1; wr_num_id_ex = 5'd5; rs_id = 5'd3; rt_id = 5'd5; uses_rt_id = 1'b0;
    step();
    uses_rt_id = 1'b1; step();
    idle(); mem_read_id_ex = 1'b1; wr_num_id_ex = 5'd0; rs_id = 5'd0; step();
    chk("filter_cnt", hz_a.stall_cnt, 2);

    // Taken branch beats a simultaneous load-use match
    idle(); branch_taken_ex = 1'b1; mem_read_id_ex = 1'b1; wr_num_id_ex = 5'd7; rs_id = 5'd7;
    step();
    chk("branch_cnt", hz_a.stall_cnt, 2);
    idle(); step();

    // Mult/div: MD=4 gives 3 freezes + release on dut_a
    do_reset();
    md_id_ex = 1'b1;
    repeat (4) step();
    idle(); step();
    chk("md_cnt_a", hz_a.stall_cnt, 3);

    // Back-to-back mult/div
    md_id_ex = 1'b1;
    repeat (8) step();
    idle(); step();

    // Reset on the 2nd freeze cycle
    do_reset();
    md_id_ex = 1'b1; step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; md_id_ex = 1'b0;
    repeat (4) step();
    chk("rst_mid_cnt_a", hz_a.stall_cnt, 0);

    // Saturation on the 4-bit counter: 20 continuous load-use stall cycles
    do_reset();
    mem_read_id_ex = 1'b1; wr_num_id_ex = 5'd9; rt_id = 5'd9; uses_rt_id = 1'b1;
    repeat (20) step();
    chk("sat_b", hz_b.stall_cnt, 15);
    chk("sat_a", hz_a.stall_cnt, 20);
    idle(); step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 99) != 0);
      rs_id           = 5'($urandom_range(0, 7));
      rt_id           = 5'($urandom_range(0, 7));
      wr_num_id_ex    = 5'($urandom_range(0, 7));
      uses_rt_id      = 1'($urandom_range(0, 1));
      mem_read_id_ex  = 1'($urandom_range(0, 1));
      md_id_ex        = ($urandom_range(0, 99) < 8);
      branch_taken_ex = ($urandom_range(0, 99) < 10);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
